signal_gen_ctrl: RTL and testbench
==================================

SIGNAL_GEN_CTRL -- requirements
Module: signal_gen_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz (informational; used by the bench for Hz conversion).
REQ-002 SHALL have port clk, input, 1, system clock; one clock, all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port enable, input, 1, start request, sampled only while idle.
REQ-005 SHALL have port stop, input, 1, graceful abort request, sampled only while busy.
REQ-006 SHALL have port period, input, 20, output period in clk cycles.
REQ-007 SHALL have port high_time, input, 20, high-level length in clk cycles.
REQ-008 SHALL have port pulse_num, input, 16, periods to emit; 0 = continuous.
REQ-009 SHALL have port sig_out, output, 1, generated waveform, registered.
REQ-010 SHALL have port busy, output, 1, high while generating.
REQ-011 SHALL have port finish, output, 1, one-clk pulse when generation ends.
REQ-012 SHALL have port err, output, 1, one-clk pulse on a rejected start.
REQ-013 SHALL have port pulse_done, output, 16, completed periods in the current or last run.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> IDLE; busy = (state == RUN).
REQ-015 SHALL, in IDLE with enable=1 and period>=2, latch period/high_time/pulse_num into working registers, clear pulse_done, and enter RUN next cycle.
REQ-016 SHALL, in IDLE with enable=1 and period<2, stay in IDLE and pulse err for one cycle; no other output changes.
REQ-017 SHALL run phase counter ph from 0 to P-1 then wrap to 0; ph=0 in the first RUN cycle.
REQ-018 SHALL drive sig_out=1 in RUN cycles where ph<H, else 0; H=0 gives constant 0, H>=P gives constant 1 (clamp, no error).
REQ-019 SHALL increment pulse_done (saturating at 16'hFFFF) at each ph wrap from P-1.
REQ-020 SHALL, when pulse_num!=0 and the wrap completes period number pulse_num, return to IDLE with finish=1 for one cycle and sig_out=0.
REQ-021 SHALL, when pulse_num==0, run until stop.
REQ-022 SHALL latch stop as pending and end at the next ph==P-1 (current period completes), with finish=1 and pulse_done counting that period; stop at ph==P-1 ends that same cycle.
REQ-023 SHALL ignore enable while busy, and ignore stop while idle.
REQ-024 SHALL give stop priority over a coincident pulse_num termination only in that both end the run; finish still pulses exactly once.
REQ-025 SHALL keep sig_out=0, ph=0 in IDLE; pulse_done holds its last value.

Reset
REQ-026 SHALL on rst=1 force state IDLE, sig_out=0, busy=0, finish=0, err=0, pulse_done=0, ph=0 and clear any pending stop, including mid-RUN.

Configuration
REQ-027 SHALL, with macro SIGGEN_SHADOW_EN defined, re-sample period/high_time into working registers at every ph wrap during RUN (the new values apply from the next period; a new period<2 is ignored and the old value kept).
REQ-028 SHALL, without SIGGEN_SHADOW_EN, use only the values latched at start for the whole run.

Verification
REQ-029 SHALL cover: period=10, high_time=3, pulse_num=4, enable -> sig_out 3 high/7 low x4, finish at 40th RUN cycle, pulse_done=4.
REQ-030 SHALL cover: period=1, enable -> err one-cycle pulse, busy stays 0.
REQ-031 SHALL cover: period=8, high_time=0 then high_time=9 runs -> sig_out constant 0, then constant 1, for 8*pulse_num cycles.
REQ-032 SHALL cover: pulse_num=0, period=5, high_time=2, stop at ph=1 of 3rd period -> ends after that period, pulse_done=3, one finish pulse.
REQ-033 SHALL cover: rst=1 at ph=4 of a period=10 run -> next cycle all outputs at reset values; new enable restarts cleanly.
REQ-034 SHALL cover, with SIGGEN_SHADOW_EN: period 10->20 mid-period 1 -> period 2 onward is 20 cycles; without the macro, it stays 10.

Source files
------------

// File: rtl/signal_gen_ctrl.sv
// Programmable pulse-train generator: period/high_time/pulse_num control.
// Define SIGGEN_SHADOW_EN to re-sample period/high_time at each period wrap.
module signal_gen_ctrl #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        stop,
    input  logic [19:0] period,
    input  logic [19:0] high_time,
    input  logic [15:0] pulse_num,
    output logic        sig_out,
    output logic        busy,
    output logic        finish,
    output logic        err,
    output logic [15:0] pulse_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [19:0] ph, ph_n;
    logic [19:0] p_w, p_n;
    logic [19:0] h_w, h_n;
    logic [15:0] n_w, n_n;
    logic [15:0] pd_n;
    logic        sp, sp_n;
    logic        sig_n, fin_n, err_n;
    logic        wrap, last;

    assign busy = (state == RUN);
    assign wrap = (ph == p_w - 20'd1);
    assign last = (n_w != 16'd0) &&
                  ({1'b0, pulse_done} + 17'd1 == {1'b0, n_w});

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ph         <= '0;
            p_w        <= '0;
            h_w        <= '0;
            n_w        <= '0;
            pulse_done <= '0;
            sp         <= 1'b0;
            sig_out    <= 1'b0;
            finish     <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            ph         <= ph_n;
            p_w        <= p_n;
            h_w        <= h_n;
            n_w        <= n_n;
            pulse_done <= pd_n;
            sp         <= sp_n;
            sig_out    <= sig_n;
            finish     <= fin_n;
            err        <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        ph_n    = ph;
        p_n     = p_w;
        h_n     = h_w;
        n_n     = n_w;
        pd_n    = pulse_done;
        sp_n    = sp;
        fin_n   = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                ph_n = '0;
                sp_n = 1'b0;
                if (enable) begin
                    if (period >= 20'd2) begin
                        p_n     = period;
                        h_n     = high_time;
                        n_n     = pulse_num;
                        pd_n    = '0;
                        state_n = RUN;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop)
                    sp_n = 1'b1;
                if (wrap) begin
                    ph_n = '0;
                    if (pulse_done != 16'hFFFF)
                        pd_n = pulse_done + 16'd1;
`ifdef SIGGEN_SHADOW_EN
                    // an invalid new period keeps the running one
                    if (period >= 20'd2)
                        p_n = period;
                    h_n = high_time;
`endif
                    // stop and count termination collapse into one finish
                    if (last || stop || sp) begin
                        state_n = IDLE;
                        sp_n    = 1'b0;
                        fin_n   = 1'b1;
                    end
                end else begin
                    ph_n = ph + 20'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        sig_n = (state_n == RUN) && (ph_n < h_n);
    end

endmodule

// File: tb/tb_signal_gen_ctrl.sv
// Directed self-checking bench for signal_gen_ctrl.
module tb_signal_gen_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        stop = 1'b0;
    logic [19:0] period = '0;
    logic [19:0] high_time = '0;
    logic [15:0] pulse_num = '0;
    logic        sig_out, busy, finish, err;
    logic [15:0] pulse_done;

    int checks = 0;
    int errors = 0;

    signal_gen_ctrl #(.CLK_FREQ(50_000_000)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .stop      (stop),
        .period    (period),
        .high_time (high_time),
        .pulse_num (pulse_num),
        .sig_out   (sig_out),
        .busy      (busy),
        .finish    (finish),
        .err       (err),
        .pulse_done(pulse_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int p, input int h, input int n);
        period    = 20'(p);
        high_time = 20'(h);
        pulse_num = 16'(n);
        enable    = 1'b1;
        tick();
        enable    = 1'b0;
    endtask

    task automatic run_n(input string tag, input int n, input int p,
                         input int h);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_sig"}, 32'(sig_out), 32'((k % p) < h));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            tick();
        end
    endtask

    task automatic chk_end(input string tag, input int pd);
        chk({tag, "_fin"}, 32'(finish), 32'd1);
        chk({tag, "_busy0"}, 32'(busy), 32'd0);
        chk({tag, "_sig0"}, 32'(sig_out), 32'd0);
        chk({tag, "_pd"}, 32'(pulse_done), 32'(pd));
        tick();
        chk({tag, "_fin1"}, 32'(finish), 32'd0);
        chk({tag, "_pdhold"}, 32'(pulse_done), 32'(pd));
    endtask

    initial begin
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sig", 32'(sig_out), 32'd0);
        chk("rst_fin", 32'(finish), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_pd", 32'(pulse_done), 32'd0);

        // 10/3 x4
        start(10, 3, 4);
        run_n("t1", 40, 10, 3);
        chk_end("t1", 4);

        // period too short: err pulse only
        period = 20'd1;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk("t2_err", 32'(err), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_pd", 32'(pulse_done), 32'd4);
        tick();
        chk("t2_err1", 32'(err), 32'd0);
        chk("t2_busy1", 32'(busy), 32'd0);

        // high_time clamps
        start(8, 0, 2);
        run_n("t3a", 16, 8, 0);
        chk_end("t3a", 2);
        start(8, 9, 2);
        run_n("t3b", 16, 8, 9);
        chk_end("t3b", 2);

        // continuous with stop at ph=1 of period 3
        start(5, 2, 0);
        for (int k = 0; k < 15; k++) begin
            chk("t4_sig", 32'(sig_out), 32'((k % 5) < 2));
            chk("t4_busy", 32'(busy), 32'd1);
            if (k == 10)
                chk("t4_pdmid", 32'(pulse_done), 32'd2);
            enable = (k == 2 || k == 3);
            stop   = (k == 11);
            tick();
        end
        enable = 1'b0;
        stop   = 1'b0;
        chk_end("t4", 3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_idle_stop_busy", 32'(busy), 32'd0);
        chk("t4_idle_stop_fin", 32'(finish), 32'd0);

        // reset mid-run, with a stop pending
        start(10, 3, 2);
        for (int k = 0; k < 5; k++) begin
            chk("t5_sig", 32'(sig_out), 32'((k % 10) < 3));
            stop = (k == 2);
            rst  = (k == 4);
            tick();
        end
        stop = 1'b0;
        rst  = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_sig0", 32'(sig_out), 32'd0);
        chk("t5_fin", 32'(finish), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_pd", 32'(pulse_done), 32'd0);
        start(10, 3, 2);
        run_n("t5r", 20, 10, 3);
        chk_end("t5r", 2);

        // period change mid-run
        start(10, 3, 3);
        begin
            int ln;
            int ep;
`ifdef SIGGEN_SHADOW_EN
            ln = 50;
`else
            ln = 30;
`endif
            for (int k = 0; k < ln; k++) begin
                ep = (k < 10) ? k : ((ln == 50) ? (k - 10) % 20 : k % 10);
                chk("t6_sig", 32'(sig_out), 32'(ep < 3));
                chk("t6_busy", 32'(busy), 32'd1);
                if (k == 5)
                    period = 20'd20;
                tick();
            end
        end
        chk_end("t6", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
